// File: rtl/button_latch.sv
// button_latch: debounces a push-button and latches a 4-bit switch value onto the LEDs per accepted press.
// Latency: press_o asserts 2 + DEBOUNCE_CYCLES cycles after a clean button rising edge; led_o/cnt_o update one cycle later.
// Backpressure: none; free-running input sampler. Holding the button yields a single press.
//
// Ports:
//   clk_i     system clock, rising edge
//   rst_ni    asynchronous active-low reset (assert is immediate, release is synchronized)
//   button_i  raw asynchronous push-button level, active-high
//   sw_i      raw 4-bit switch value, sampled only on an accepted press
//   led_o     displayed captured switch value
//   press_o   one-cycle pulse per accepted press
//   cnt_o     accepted press count, wraps modulo 256
//   busy_o    high whenever the FSM is not IDLE
//
// Optional feature: define BUTTON_LATCH_BLINK_EN to blink led_o with a half-period of
// BLINK_HALF cycles. Without it led_o follows the LED register and no blink logic exists.

module button_latch #(
    parameter int unsigned DEBOUNCE_CYCLES = 8,
    parameter int unsigned BLINK_HALF      = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       button_i,
    input  logic [3:0] sw_i,
    output logic [3:0] led_o,
    output logic       press_o,
    output logic [7:0] cnt_o,
    output logic       busy_o
);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
        $error("button_latch: DEBOUNCE_CYCLES must be in 2..255");
    end
    if (BLINK_HALF < 2 || BLINK_HALF > 65535) begin : g_bad_blink
        $error("button_latch: BLINK_HALF must be in 2..65535");
    end

    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        HELD       = 2'd2,
        DB_RELEASE = 2'd3
    } state_t;

    // Reset assert is asynchronous; release is retimed through two flops so
    // every other register leaves reset on a clean clock edge.
    logic [1:0] rst_sync;
    logic       arst_n;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign arst_n = rst_sync[1];

    // Two-flop synchronizers for the raw asynchronous inputs.
    logic       btn_meta;
    logic       btn_sync;
    logic [3:0] sw_meta;
    logic [3:0] sw_sync;

    always_ff @(posedge clk_i or negedge arst_n) begin
        if (!arst_n) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
            sw_meta  <= 4'h0;
            sw_sync  <= 4'h0;
        end else begin
            btn_meta <= button_i;
            btn_sync <= btn_meta;
            sw_meta  <= sw_i;
            sw_sync  <= sw_meta;
        end
    end

    // Debounce FSM
    state_t     state;
    state_t     state_next;
    logic [7:0] db_cnt;
    logic [7:0] db_cnt_next;
    logic       accept;

    always_ff @(posedge clk_i or negedge arst_n) begin
        if (!arst_n) begin
            state  <= IDLE;
            db_cnt <= 8'd0;
        end else begin
            state  <= state_next;
            db_cnt <= db_cnt_next;
        end
    end

    always_comb begin
        state_next  = state;
        db_cnt_next = db_cnt;
        accept      = 1'b0;
        case (state)
            IDLE: begin
                if (btn_sync) begin
                    state_next  = DB_PRESS;
                    db_cnt_next = 8'd0;
                end
            end
            DB_PRESS: begin
                if (!btn_sync) begin
                    state_next = IDLE;          // glitch: drop without capture
                end else if (db_cnt == DB_LAST) begin
                    state_next = HELD;
                    accept     = 1'b1;
                end else begin
                    db_cnt_next = db_cnt + 8'd1;
                end
            end
            HELD: begin
                if (!btn_sync) begin
                    state_next  = DB_RELEASE;
                    db_cnt_next = 8'd0;
                end
            end
            DB_RELEASE: begin
                if (btn_sync) begin
                    state_next = HELD;          // release bounce: no new press
                end else if (db_cnt == DB_LAST) begin
                    state_next = IDLE;
                end else begin
                    db_cnt_next = db_cnt + 8'd1;
                end
            end
            default: begin
                state_next  = IDLE;
                db_cnt_next = 8'd0;
            end
        endcase
    end

    // accept is decoded from registered state/counter and the synchronized
    // button only, so press_o is glitch-free and lasts exactly the cycle in
    // which the capture edge is pending.
    assign press_o = accept;
    assign busy_o  = (state != IDLE);

    // Capture register and press counter, both updated on the accept edge.
    logic [3:0] led_reg;
    logic [7:0] press_cnt;

    always_ff @(posedge clk_i or negedge arst_n) begin
        if (!arst_n) begin
            led_reg   <= 4'h0;
            press_cnt <= 8'd0;
        end else if (accept) begin
            led_reg   <= sw_sync;
            press_cnt <= press_cnt + 8'd1;   // natural wrap 255 -> 0
        end
    end

    assign cnt_o = press_cnt;

`ifdef BUTTON_LATCH_BLINK_EN
    localparam logic [15:0] BLINK_LAST = 16'(BLINK_HALF - 1);

    logic [15:0] blink_cnt;
    logic        blink_on;

    // Each accepted press restarts the blink at the start of an on phase.
    always_ff @(posedge clk_i or negedge arst_n) begin
        if (!arst_n) begin
            blink_cnt <= 16'd0;
            blink_on  <= 1'b0;
        end else if (accept) begin
            blink_cnt <= 16'd0;
            blink_on  <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= 16'd0;
            blink_on  <= ~blink_on;
        end else begin
            blink_cnt <= blink_cnt + 16'd1;
        end
    end

    assign led_o = blink_on ? led_reg : 4'h0;
`else
    assign led_o = led_reg;
`endif

endmodule

// File: tb/tb_button_latch.sv
// tb_button_latch: directed bench for button_latch with a queue of expected press captures.
// Latency: checks press_o at 2 + DEBOUNCE_CYCLES cycles after the button edge.
// Backpressure: not applicable.

module tb_button_latch;

    logic       clk_i    = 1'b0;
    logic       rst_ni   = 1'b0;
    logic       button_i = 1'b0;
    logic [3:0] sw_i     = 4'h1;
    logic [3:0] led_o;
    logic       press_o;
    logic [7:0] cnt_o;
    logic       busy_o;

    button_latch #(
        .DEBOUNCE_CYCLES(8),
        .BLINK_HALF     (16)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .button_i(button_i),
        .sw_i    (sw_i),
        .led_o   (led_o),
        .press_o (press_o),
        .cnt_o   (cnt_o),
        .busy_o  (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [3:0] led;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   pulses      = 0;

    always @(negedge clk_i) begin
        if (press_o === 1'b1) pulses++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and leave the bench 1 time unit after the last one.
    task automatic cycles(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Returns the number of rising edges until press_o is seen (sampled on
    // the falling edge), or -1 if the budget runs out. Ends on a falling edge.
    task automatic wait_press(input int budget, output int cyc);
        cyc = -1;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            if (press_o === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        int   p0;
        exp_t e;
        logic [3:0] last_sw;

        // Reset held low for 100 ns with sw_i = 1
        #22 check("reset_outs_a", {led_o, cnt_o, press_o, busy_o}, 14'h0);
        #30 check("reset_outs_b", {led_o, cnt_o, press_o, busy_o}, 14'h0);
        #40 check("reset_outs_c", {led_o, cnt_o, press_o, busy_o}, 14'h0);
        #8  rst_ni = 1'b1;
        cycles(5);
        check("post_reset_idle", {led_o, cnt_o, press_o, busy_o}, 14'h0);

        // Clean press of 20 cycles with sw = 2
        sw_i     = 4'h2;
        p0       = pulses;
        sb.push_back('{led: 4'h2, cnt: 8'd1});
        button_i = 1'b1;
        wait_press(30, cyc);
        check("press_latency", cyc, 10);
        check("busy_while_held", busy_o, 1'b1);
        cycles(10);
        button_i = 1'b0;
        cycles(15);
        e = sb.pop_front();
        check("press1_led", led_o, e.led);
        check("press1_cnt", cnt_o, e.cnt);
        check("press1_pulses", pulses - p0, 1);
        check("press1_idle", busy_o, 1'b0);

        // 3-cycle glitch, with sw changed: nothing may move
        p0       = pulses;
        sw_i     = 4'h3;
        button_i = 1'b1;
        cycles(3);
        button_i = 1'b0;
        cycles(12);
        check("glitch_pulses", pulses - p0, 0);
        check("glitch_led", led_o, 4'h2);
        check("glitch_cnt", cnt_o, 8'd1);
        check("glitch_idle", busy_o, 1'b0);

        // Hold for ~1000 cycles, then release with a 2-cycle bounce
        sw_i     = 4'h5;
        p0       = pulses;
        sb.push_back('{led: 4'h5, cnt: 8'd2});
        button_i = 1'b1;
        wait_press(30, cyc);
        check("hold_latency", cyc, 10);
        cycles(990);
        button_i = 1'b0;
        cycles(3);
        button_i = 1'b1;
        cycles(2);
        button_i = 1'b0;
        sw_i     = 4'hF;
        repeat (10) @(posedge clk_i);
        @(negedge clk_i);
        check("release_still_busy", busy_o, 1'b1);
        @(posedge clk_i);
        @(negedge clk_i);
        check("release_idle", busy_o, 1'b0);
        e = sb.pop_front();
        check("hold_pulses", pulses - p0, 1);
        check("hold_led", led_o, e.led);
        check("hold_cnt", cnt_o, e.cnt);

        // Reset asserted mid-debounce aborts with no press
        cycles(1);
        p0       = pulses;
        sw_i     = 4'h7;
        button_i = 1'b1;
        cycles(6);
        check("debounce_busy", busy_o, 1'b1);
        rst_ni = 1'b0;
        #1 check("abort_outs", {led_o, cnt_o, press_o, busy_o}, 14'h0);
        button_i = 1'b0;
        cycles(3);
        rst_ni = 1'b1;
        cycles(6);
        check("abort_pulses", pulses - p0, 0);
        check("abort_idle", {cnt_o, busy_o}, 9'h0);

        // 257 clean presses from a zero count: wrap to 1
        p0      = pulses;
        last_sw = 4'h0;
        for (int i = 0; i < 257; i++) begin
            last_sw  = 4'($urandom_range(0, 15));
            sw_i     = last_sw;
            sb.push_back('{led: last_sw, cnt: 8'((i + 1) % 256)});
            button_i = 1'b1;
            cycles(13);
            e = sb.pop_front();
            check($sformatf("press_%0d", i), {led_o, cnt_o}, {e.led, e.cnt});
            button_i = 1'b0;
            cycles(13);
        end
        check("wrap_cnt", cnt_o, 8'd1);
        check("wrap_led", led_o, last_sw);
        check("wrap_pulses", pulses - p0, 257);

`ifdef BUTTON_LATCH_BLINK_EN
        // Blink pattern after capturing 4'hA, then reset mid-blink
        rst_ni = 1'b0;
        cycles(3);
        rst_ni = 1'b1;
        cycles(5);
        sw_i     = 4'hA;
        button_i = 1'b1;
        wait_press(30, cyc);
        check("blink_latency", cyc, 10);
        for (int k = 1; k <= 65; k++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            check($sformatf("blink_%0d", k), led_o, ((((k - 1) / 16) % 2) == 0) ? 4'hA : 4'h0);
        end
        #2 rst_ni = 1'b0;
        #1 check("blink_reset_led", led_o, 4'h0);
        button_i = 1'b0;
        cycles(2);
        rst_ni = 1'b1;
        cycles(3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
